// File: rtl/lsu_hs.sv
// Handshaked load/store unit: one request per two cycles, fixed two-edge response latency.
// Routes accesses to registered data memory, memory-mapped output registers or synchronised switches.
module lsu_hs #(
  parameter int          DMEM_DEPTH = 512,
  parameter int          NUM_IO_OUT = 8,
  parameter logic [15:0] DMEM_BASE  = 16'h0000,
  parameter logic [15:0] IO_BASE    = 16'h1000,
  parameter logic [15:0] SW_BASE    = 16'h1001
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic                    i_req_wren,
  input  logic [31:0]             i_req_addr,
  input  logic [31:0]             i_req_wdata,
  input  logic [1:0]              i_lsu_op,
  input  logic                    i_ld_un,
  output logic                    o_rsp_valid,
  output logic [31:0]             o_ld_data,
  output logic                    o_misalign,
  input  logic [31:0]             i_io_sw,
  output logic [32*NUM_IO_OUT-1:0] o_io_out
);
  localparam int AW = $clog2(DMEM_DEPTH);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state;

  logic [31:0] q_addr, q_wdata;
  logic        q_wren, q_un;
  logic [1:0]  q_op;

  logic [31:0]                  mem [DMEM_DEPTH];
  logic [NUM_IO_OUT-1:0][31:0]  io_reg;
  logic [31:0]                  sw_meta, sw_sync;

  logic          accept;
  logic [15:0]   tag;
  logic [AW-1:0] widx;
  logic [3:0]    io_idx;
  logic          dm_hit, io_hit, sw_hit, mis;
  logic [3:0]    be;
  logic [31:0]   wlane, rword, ld_val;
  logic [15:0]   hsel;
  logic [7:0]    bsel;

  assign o_req_ready = (state != ACCESS);
  assign accept      = i_req_valid & o_req_ready;
  assign o_io_out    = io_reg;

  assign tag    = q_addr[31:16];
  assign widx   = q_addr[AW+1:2];
  assign io_idx = q_addr[15:12];

  // Decode, lane steering and load extension all work on the captured request.
  always_comb begin
    dm_hit = (tag == DMEM_BASE) && ((q_addr[15:0] >> (AW + 2)) == 16'd0);
    io_hit = (tag == IO_BASE) && ({28'd0, io_idx} < 32'(NUM_IO_OUT));
    sw_hit = (tag == SW_BASE);
    case (q_op)
      2'b10: begin
        mis   = q_addr[0];
        be    = q_addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{q_wdata[15:0]}};
      end
      2'b11: begin
        mis   = 1'b0;
        be    = 4'b0001 << q_addr[1:0];
        wlane = {4{q_wdata[7:0]}};
      end
      default: begin
        mis   = |q_addr[1:0];
        be    = 4'b1111;
        wlane = q_wdata;
      end
    endcase
    rword = 32'd0;
    if (dm_hit) rword = mem[widx];
    else if (io_hit) begin
      for (int k = 0; k < NUM_IO_OUT; k++)
        if (io_idx == 4'(k)) rword = io_reg[k];
    end else if (sw_hit) rword = sw_sync;
    hsel = q_addr[1] ? rword[31:16] : rword[15:0];
    bsel = rword[{q_addr[1:0], 3'b000} +: 8];
    case (q_op)
      2'b10:   ld_val = {{16{~q_un & hsel[15]}}, hsel};
      2'b11:   ld_val = {{24{~q_un & bsel[7]}}, bsel};
      default: ld_val = rword;
    endcase
  end

  // Data memory is deliberately left without reset.
  always_ff @(posedge i_clk) begin
    if (state == ACCESS && q_wren && !mis && dm_hit)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[widx][8*i +: 8] <= wlane[8*i +: 8];
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state       <= IDLE;
      o_rsp_valid <= 1'b0;
      o_misalign  <= 1'b0;
      o_ld_data   <= 32'd0;
      io_reg      <= '0;
      sw_meta     <= 32'd0;
      sw_sync     <= 32'd0;
      q_addr      <= 32'd0;
      q_wdata     <= 32'd0;
      q_wren      <= 1'b0;
      q_un        <= 1'b0;
      q_op        <= 2'b00;
    end else begin
      sw_meta <= i_io_sw;
      sw_sync <= sw_meta;
      if (accept) begin
        q_addr  <= i_req_addr;
        q_wdata <= i_req_wdata;
        q_wren  <= i_req_wren;
        q_un    <= i_ld_un;
        q_op    <= i_lsu_op;
      end
      case (state)
        IDLE: begin
          o_rsp_valid <= 1'b0;
          o_misalign  <= 1'b0;
          if (accept) state <= ACCESS;
        end
        ACCESS: begin
          if (q_wren && !mis && io_hit)
            for (int k = 0; k < NUM_IO_OUT; k++)
              if (io_idx == 4'(k))
                for (int i = 0; i < 4; i++)
                  if (be[i]) io_reg[k][8*i +: 8] <= wlane[8*i +: 8];
          o_rsp_valid <= 1'b1;
          o_misalign  <= mis;
          o_ld_data   <= (q_wren || mis) ? 32'd0 : ld_val;
          state       <= RESP;
        end
        RESP: begin
          o_rsp_valid <= 1'b0;
          o_misalign  <= 1'b0;
          state       <= accept ? ACCESS : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_hs.sv
// Self-checking bench for lsu_hs: directed scenarios plus randomized traffic against a
// byte-lane reference model of memory, output registers and switches.
module tb_lsu_hs;
  localparam int DEPTH = 512;
  localparam int NIO   = 8;

  logic              i_clk = 1'b0, i_reset = 1'b0;
  logic              i_req_valid = 1'b0, i_req_wren = 1'b0, i_ld_un = 1'b0;
  logic [31:0]       i_req_addr = '0, i_req_wdata = '0, i_io_sw = '0;
  logic [1:0]        i_lsu_op = '0;
  logic              o_req_ready, o_rsp_valid, o_misalign;
  logic [31:0]       o_ld_data;
  logic [32*NIO-1:0] o_io_out;

  int checks = 0, failures = 0;
  logic [31:0] mdm [DEPTH];
  logic [31:0] mio [NIO];

  lsu_hs #(.DMEM_DEPTH(DEPTH), .NUM_IO_OUT(NIO)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_wren(i_req_wren), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .i_lsu_op(i_lsu_op), .i_ld_un(i_ld_un), .o_rsp_valid(o_rsp_valid), .o_ld_data(o_ld_data),
    .o_misalign(o_misalign), .i_io_sw(i_io_sw), .o_io_out(o_io_out)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  // Drives one request from a negedge; returns ready seen in the cycle after accept and the
  // response seen one cycle later. Caller is left at the negedge inside the response cycle.
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] op, input logic un,
                       output logic rdy_acc, output logic vld1, output logic [31:0] d, output logic m);
    int cnt = 0;
    i_req_valid = 1'b1; i_req_wren = wr; i_req_addr = a; i_req_wdata = wd;
    i_lsu_op = op; i_ld_un = un;
    while (!o_req_ready && cnt < 20) begin @(negedge i_clk); cnt++; end
    if (cnt >= 20) begin
      checks++; failures++;
      $display("FAIL accept_timeout addr=%h ready stayed low for %0d cycles", a, cnt);
    end
    @(negedge i_clk);
    i_req_valid = 1'b0;
    rdy_acc = o_req_ready;
    @(negedge i_clk);
    vld1 = o_rsp_valid; d = o_ld_data; m = o_misalign;
  endtask

  // Reference: the spec's rules applied to a word array with plain shift/mask arithmetic.
  task automatic model_req(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                           input logic [1:0] op, input logic un,
                           output logic [31:0] ed, output logic em);
    int size, sh, region;
    logic [31:0] mask, old, v;
    size = (op[1] == 1'b0) ? 32 : (op[0] ? 8 : 16);
    sh   = (size == 32) ? 0 : ((size == 16) ? 16 * int'(a[1]) : 8 * int'(a[1:0]));
    em   = (a % (size / 8)) != 0;
    mask = (size == 32) ? 32'hFFFF_FFFF : ((32'd1 << size) - 32'd1);
    region = 0;
    if (a[31:16] == 16'h0000 && a[15:0] < DEPTH * 4) region = 1;
    else if (a[31:16] == 16'h1000 && int'(a[15:12]) < NIO) region = 2;
    else if (a[31:16] == 16'h1001) region = 3;
    case (region)
      1: old = mdm[a[15:0] / 4];
      2: old = mio[a[15:12]];
      3: old = i_io_sw;
      default: old = 32'd0;
    endcase
    ed = 32'd0;
    if (!em) begin
      if (wr) begin
        v = (old & ~(mask << sh)) | ((wd & mask) << sh);
        if (region == 1) mdm[a[15:0] / 4] = v;
        if (region == 2) mio[a[15:12]] = v;
      end else begin
        v = (old >> sh) & mask;
        if (!un && size < 32 && v[size-1]) v = v | ~mask;
        ed = v;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge i_clk);
    checks++; if (o_rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", o_rsp_valid); end
    checks++; if (o_misalign !== 1'b0) begin failures++; $display("FAIL reset_misalign got=%b exp=0", o_misalign); end
    checks++; if (o_ld_data !== 32'd0) begin failures++; $display("FAIL reset_ld_data got=%h exp=0", o_ld_data); end
    checks++; if (o_io_out !== '0) begin failures++; $display("FAIL reset_io_out got=%h exp=0", o_io_out); end
    i_reset = 1'b1;
    checks++; if (o_req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", o_req_ready); end
  endtask

  task automatic test_word();
    logic r, v, m; logic [31:0] d;
    @(negedge i_clk);
    issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 2'b00, 1'b0, r, v, d, m);
    checks++; if (r !== 1'b0) begin failures++; $display("FAIL word_st_ready_access got=%b exp=0", r); end
    checks++; if (v !== 1'b1) begin failures++; $display("FAIL word_st_rsp got=%b exp=1", v); end
    checks++; if (m !== 1'b0) begin failures++; $display("FAIL word_st_mis got=%b exp=0", m); end
    @(negedge i_clk);
    checks++; if (o_rsp_valid !== 1'b0) begin failures++; $display("FAIL word_st_rsp_one_cycle got=%b exp=0", o_rsp_valid); end
    issue(1'b0, 32'h0000_0010, 32'h0, 2'b00, 1'b0, r, v, d, m);
    checks++; if (r !== 1'b0) begin failures++; $display("FAIL word_ld_ready_access got=%b exp=0", r); end
    checks++; if (v !== 1'b1 || d !== 32'hDEAD_BEEF) begin failures++; $display("FAIL word_ld got v=%b d=%h exp v=1 d=deadbeef", v, d); end
    @(negedge i_clk);
    checks++; if (o_ld_data !== 32'hDEAD_BEEF || o_rsp_valid !== 1'b0) begin failures++; $display("FAIL ld_data_hold got d=%h v=%b exp d=deadbeef v=0", o_ld_data, o_rsp_valid); end
  endtask

  task automatic test_byte_half();
    logic r, v, m; logic [31:0] d;
    issue(1'b0, 32'h0000_0013, 32'h0, 2'b11, 1'b0, r, v, d, m);
    checks++; if (d !== 32'hFFFF_FFDE) begin failures++; $display("FAIL byte_ld_signed got=%h exp=ffffffde", d); end
    issue(1'b0, 32'h0000_0013, 32'h0, 2'b11, 1'b1, r, v, d, m);
    checks++; if (v !== 1'b1 || d !== 32'h0000_00DE) begin failures++; $display("FAIL byte_ld_unsigned got v=%b d=%h exp v=1 d=000000de", v, d); end
    issue(1'b1, 32'h0000_0012, 32'hAAAA_1234, 2'b10, 1'b0, r, v, d, m);
    issue(1'b0, 32'h0000_0010, 32'h0, 2'b00, 1'b0, r, v, d, m);
    checks++; if (d !== 32'h1234_BEEF) begin failures++; $display("FAIL half_st_word_ld got=%h exp=1234beef", d); end
  endtask

  task automatic test_misalign();
    logic r, v, m; logic [31:0] d;
    issue(1'b1, 32'h0000_0011, 32'h5555_5555, 2'b00, 1'b0, r, v, d, m);
    checks++; if (v !== 1'b1 || m !== 1'b1) begin failures++; $display("FAIL mis_word_st got v=%b m=%b exp v=1 m=1", v, m); end
    issue(1'b0, 32'h0000_0010, 32'h0, 2'b00, 1'b0, r, v, d, m);
    checks++; if (d !== 32'h1234_BEEF || m !== 1'b0) begin failures++; $display("FAIL mis_mem_unchanged got d=%h m=%b exp d=1234beef m=0", d, m); end
    issue(1'b0, 32'h1000_0001, 32'h0, 2'b10, 1'b0, r, v, d, m);
    checks++; if (m !== 1'b1 || d !== 32'd0) begin failures++; $display("FAIL mis_half_ld got d=%h m=%b exp d=0 m=1", d, m); end
  endtask

  task automatic test_io();
    logic r, v, m; logic [31:0] d; logic [32*NIO-1:0] e;
    issue(1'b1, 32'h1000_2000, 32'h0000_007F, 2'b00, 1'b0, r, v, d, m);
    checks++; if (o_io_out[95:64] !== 32'h7F) begin failures++; $display("FAIL io_store got=%h exp=0000007f", o_io_out[95:64]); end
    issue(1'b1, 32'h1000_9000, 32'h0000_0055, 2'b00, 1'b0, r, v, d, m);
    e = '0; e[95:64] = 32'h7F;
    checks++; if (v !== 1'b1 || m !== 1'b0) begin failures++; $display("FAIL io_unmapped_rsp got v=%b m=%b exp v=1 m=0", v, m); end
    checks++; if (o_io_out !== e) begin failures++; $display("FAIL io_unmapped_drop got=%h exp=%h", o_io_out, e); end
    issue(1'b0, 32'h1000_2000, 32'h0, 2'b00, 1'b0, r, v, d, m);
    checks++; if (d !== 32'h7F) begin failures++; $display("FAIL io_load got=%h exp=0000007f", d); end
    issue(1'b0, 32'h1000_9000, 32'h0, 2'b00, 1'b0, r, v, d, m);
    checks++; if (d !== 32'd0 || m !== 1'b0) begin failures++; $display("FAIL io_unmapped_load got d=%h m=%b exp d=0 m=0", d, m); end
  endtask

  task automatic test_switch();
    logic r, v, m; logic [31:0] d;
    @(negedge i_clk); i_io_sw = 32'h0000_8001;
    repeat (3) @(negedge i_clk);
    issue(1'b0, 32'h1001_0000, 32'h0, 2'b10, 1'b0, r, v, d, m);
    checks++; if (d !== 32'hFFFF_8001) begin failures++; $display("FAIL sw_half_signed got=%h exp=ffff8001", d); end
    @(negedge i_clk); i_io_sw = 32'h1234_5678;
    issue(1'b0, 32'h1001_0000, 32'h0, 2'b00, 1'b0, r, v, d, m);
    checks++; if (d !== 32'h0000_8001) begin failures++; $display("FAIL sw_sync_old got=%h exp=00008001", d); end
    repeat (3) @(negedge i_clk);
    issue(1'b0, 32'h1001_0000, 32'h0, 2'b00, 1'b0, r, v, d, m);
    checks++; if (d !== 32'h1234_5678) begin failures++; $display("FAIL sw_sync_new got=%h exp=12345678", d); end
  endtask

  task automatic test_reset_access();
    logic r, v, m; logic [31:0] d;
    @(negedge i_clk);
    i_req_valid = 1'b1; i_req_wren = 1'b1; i_req_addr = 32'h1000_0000;
    i_req_wdata = 32'h0000_00AA; i_lsu_op = 2'b00;
    @(negedge i_clk);
    i_req_valid = 1'b0;
    checks++; if (o_req_ready !== 1'b0) begin failures++; $display("FAIL rst_acc_in_access got=%b exp=0", o_req_ready); end
    i_reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      checks++; if (o_rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_acc_no_rsp cycle=%0d got=%b exp=0", i, o_rsp_valid); end
    end
    i_reset = 1'b1;
    checks++; if (o_io_out[31:0] !== 32'd0) begin failures++; $display("FAIL rst_acc_io got=%h exp=0", o_io_out[31:0]); end
    // Abort a DMEM store the same way; memory keeps its old word.
    @(negedge i_clk);
    i_req_valid = 1'b1; i_req_wren = 1'b1; i_req_addr = 32'h0000_0010;
    i_req_wdata = 32'hCAFE_F00D; i_lsu_op = 2'b00;
    @(negedge i_clk);
    i_req_valid = 1'b0; i_reset = 1'b0;
    @(negedge i_clk);
    i_reset = 1'b1;
    checks++; if (o_rsp_valid !== 1'b0 || o_ld_data !== 32'd0) begin failures++; $display("FAIL rst_acc_outputs got v=%b d=%h exp v=0 d=0", o_rsp_valid, o_ld_data); end
    issue(1'b0, 32'h0000_0010, 32'h0, 2'b00, 1'b0, r, v, d, m);
    checks++; if (d !== 32'h1234_BEEF) begin failures++; $display("FAIL rst_acc_dmem got=%h exp=1234beef", d); end
    for (int k = 0; k < NIO; k++) mio[k] = 32'd0;
  endtask

  task automatic test_random();
    logic r, v, m, em, wr, un; logic [31:0] d, ed, a, wd; logic [1:0] op;
    logic [32*NIO-1:0] e;
    // Known contents for the low DMEM window used below.
    for (int w = 0; w < 32; w++) begin
      model_req(1'b1, 32'(w * 4), 32'd0, 2'b00, 1'b0, ed, em);
      issue(1'b1, 32'(w * 4), 32'd0, 2'b00, 1'b0, r, v, d, m);
    end
    for (int n = 0; n < 120; n++) begin
      case ($urandom_range(0, 4))
        0: a = 32'($urandom_range(0, 127));
        1: a = 32'h0000_0800 | ($urandom & 32'h7FF);
        2: a = 32'h1000_0000 | (32'($urandom_range(0, 15)) << 12) | ($urandom & 32'hF);
        3: a = 32'h1001_0000 | ($urandom & 32'hFF);
        default: a = 32'h2000_0000 | ($urandom & 32'hFFFF);
      endcase
      wr = 1'($urandom); un = 1'($urandom); op = 2'($urandom); wd = $urandom;
      model_req(wr, a, wd, op, un, ed, em);
      issue(wr, a, wd, op, un, r, v, d, m);
      checks++;
      if (v !== 1'b1 || m !== em || (!wr && d !== ed)) begin
        failures++;
        $display("FAIL rand[%0d] wr=%b op=%b un=%b a=%h got v=%b m=%b d=%h exp v=1 m=%b d=%h",
                 n, wr, op, un, a, v, m, d, em, ed);
      end
    end
    for (int k = 0; k < NIO; k++) e[32*k +: 32] = mio[k];
    checks++; if (o_io_out !== e) begin failures++; $display("FAIL rand_io_out got=%h exp=%h", o_io_out, e); end
  endtask

  initial begin
    for (int k = 0; k < NIO; k++) mio[k] = 32'd0;
    test_reset();
    test_word();
    test_byte_half();
    test_misalign();
    test_io();
    test_switch();
    test_reset_access();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
